// File: rtl/qar_bus_pkg.sv
// Shared definitions for the QAR peripheral register bus: bridge FSM
// encoding, peripheral window location and fixed slot assignments.
package qar_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } bridge_state_t;

   // 128-byte slots give 32 word registers per peripheral (addr_word[4:0]).
   localparam int          QAR_SLOT_BITS   = 7;
   localparam int          QAR_NUM_SLAVES  = 4;
   localparam logic [31:0] QAR_PERIPH_BASE = 32'h4000_0000;

   // Slot assignment inside the peripheral window.
   localparam int SLOT_GPIO  = 0;
   localparam int SLOT_TIMER = 1;
   localparam int SLOT_UART  = 2;
   localparam int SLOT_SPARE = 3;

endpackage

// File: rtl/qar_addr_decode.sv
// Combinational byte-address decoder for the QAR peripheral window.
// Reports window hit, slot index, word alignment and word offset in slot.
module qar_addr_decode #(
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
   parameter int          NUM_SLAVES = 4,
   parameter int          SLOT_BITS  = 7,
   localparam int         IDX_BITS   = $clog2(NUM_SLAVES)
) (
   input  logic [31:0]         addr_i,
   output logic                hit_o,
   output logic [IDX_BITS-1:0] slot_o,
   output logic                aligned_o,
   output logic [4:0]          addr_word_o
);

   // Lowest address bit above the whole window (all slots).
   localparam int WIN_LSB = SLOT_BITS + IDX_BITS;

   assign hit_o       = (addr_i[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
   assign slot_o      = addr_i[WIN_LSB-1:SLOT_BITS];
   assign aligned_o   = (addr_i[1:0] == 2'b00);
   assign addr_word_o = addr_i[6:2];

endmodule

// File: rtl/qar_periph_bridge.sv
// Initiator bridge from a CPU load/store request channel onto the QAR
// word-addressed peripheral bus. One request in flight at a time; each
// access walks IDLE -> SETUP -> ACCESS -> RESP, errors skip ACCESS.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where
// resp_valid and resp_ready are both 1. resp_* stay stable while
// resp_valid=1 and resp_ready=0.
module qar_periph_bridge
   import qar_bus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = QAR_PERIPH_BASE,
   parameter int          NUM_SLAVES = QAR_NUM_SLAVES,
   parameter int          SLOT_BITS  = QAR_SLOT_BITS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [31:0]              req_addr,
   input  logic [31:0]              req_wdata,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [31:0]              resp_rdata,
   output logic                     resp_err,
   output logic [NUM_SLAVES-1:0]    periph_write_en,
   output logic [NUM_SLAVES-1:0]    periph_read_en,
   output logic [4:0]               periph_addr_word,
   output logic [31:0]              periph_wdata,
   input  logic [NUM_SLAVES*32-1:0] periph_rdata,
   output bridge_state_t            dbg_state
);

   localparam int IDX_BITS = $clog2(NUM_SLAVES);

   bridge_state_t         state_q;
   logic                  req_ready_q;
   logic                  resp_valid_q;
   logic [31:0]           resp_rdata_q;
   logic                  resp_err_q;
   logic [NUM_SLAVES-1:0] write_en_q;
   logic [NUM_SLAVES-1:0] read_en_q;
   logic [4:0]            addr_word_q;
   logic [31:0]           wdata_q;
   logic                  we_q;
   logic                  err_q;
   logic [IDX_BITS-1:0]   slot_q;

   logic                  dec_hit;
   logic                  dec_aligned;
   logic [IDX_BITS-1:0]   dec_slot;
   logic [4:0]            dec_addr_word;
   logic [NUM_SLAVES-1:0] slot_onehot;
   logic [31:0]           rd_sel;

   qar_addr_decode #(
      .BASE_ADDR  (BASE_ADDR),
      .NUM_SLAVES (NUM_SLAVES),
      .SLOT_BITS  (SLOT_BITS)
   ) u_decode (
      .addr_i      (req_addr),
      .hit_o       (dec_hit),
      .slot_o      (dec_slot),
      .aligned_o   (dec_aligned),
      .addr_word_o (dec_addr_word)
   );

   // One-hot strobe pattern for the latched slot.
   always_comb begin
      slot_onehot         = '0;
      slot_onehot[slot_q] = 1'b1;
   end

   // Select the latched slot's combinational read data.
   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (slot_q == IDX_BITS'(i)) rd_sel = periph_rdata[32*i +: 32];
      end
   end

   // Bridge FSM; every output is a register updated here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         write_en_q   <= '0;
         read_en_q    <= '0;
         addr_word_q  <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         slot_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q        <= req_we;
                  slot_q      <= dec_slot;
                  err_q       <= ~(dec_hit & dec_aligned);
                  addr_word_q <= dec_addr_word;
                  wdata_q     <= req_wdata;
                  req_ready_q <= 1'b0;
                  state_q     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (err_q) begin
                  // Bad address: answer directly, never strobe a peripheral.
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= '0;
                  state_q      <= ST_RESP;
               end else begin
                  if (we_q) write_en_q <= slot_onehot;
                  else      read_en_q  <= slot_onehot;
                  state_q <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               write_en_q   <= '0;
               read_en_q    <= '0;
               if (!we_q) resp_rdata_q <= rd_sel;
               resp_valid_q <= 1'b1;
               state_q      <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  resp_rdata_q <= '0;
                  resp_err_q   <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready        = req_ready_q;
   assign resp_valid       = resp_valid_q;
   assign resp_rdata       = resp_rdata_q;
   assign resp_err         = resp_err_q;
   assign periph_write_en  = write_en_q;
   assign periph_read_en   = read_en_q;
   assign periph_addr_word = addr_word_q;
   assign periph_wdata     = wdata_q;
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_qar_periph_bridge.sv
// Bench for qar_periph_bridge: CPU-side driver, a GPIO register model on
// slot 0, constant-data slaves on slots 1..3 and an expected-response queue.
module tb_qar_periph_bridge;

   logic         clk;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic         req_we;
   logic [31:0]  req_addr;
   logic [31:0]  req_wdata;
   logic         resp_valid;
   logic         resp_ready;
   logic [31:0]  resp_rdata;
   logic         resp_err;
   logic [3:0]   periph_write_en;
   logic [3:0]   periph_read_en;
   logic [4:0]   periph_addr_word;
   logic [31:0]  periph_wdata;
   logic [127:0] periph_rdata;
   logic [1:0]   dbg_state;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int wr_pulses = 0;
   int rd_pulses = 0;
   int last_wr_cyc = -100;
   int last_rd_cyc = -100;

   logic [32:0] exp_q[$];
   logic [31:0] gpio_regs [32] = '{default: 32'h0};
   logic [31:0] slot_rd1 = 32'h0;
   logic [31:0] slot_rd2 = 32'h0;
   logic [31:0] slot_rd3 = 32'h0;

   qar_periph_bridge dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_we           (req_we),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_ready       (resp_ready),
      .resp_rdata       (resp_rdata),
      .resp_err         (resp_err),
      .periph_write_en  (periph_write_en),
      .periph_read_en   (periph_read_en),
      .periph_addr_word (periph_addr_word),
      .periph_wdata     (periph_wdata),
      .periph_rdata     (periph_rdata),
      .dbg_state        (dbg_state)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Peripheral models: GPIO registers on slot 0, fixed data elsewhere.
   assign periph_rdata = {slot_rd3, slot_rd2, slot_rd1, gpio_regs[periph_addr_word]};

   always @(posedge clk) begin
      if (periph_write_en[0]) gpio_regs[periph_addr_word] <= periph_wdata;
   end

   // Strobe activity log, sampled mid-cycle.
   always @(negedge clk) begin
      if (|periph_write_en) begin
         wr_pulses   <= wr_pulses + 1;
         last_wr_cyc <= cyc;
      end
      if (|periph_read_en) begin
         rd_pulses   <= rd_pulses + 1;
         last_rd_cyc <= cyc;
      end
   end

   // Reference response for an access: window is 0x4000_0000..0x4000_01FF.
   function automatic logic [32:0] model_resp(input logic we, input logic [31:0] addr);
      logic        err;
      logic [31:0] d;
      err = (addr[31:9] != 23'h20_0000) || (addr[1:0] != 2'b00);
      d   = 32'h0;
      if (!err && !we) begin
         case (addr[8:7])
            2'd0: d = gpio_regs[addr[6:2]];
            2'd1: d = slot_rd1;
            2'd2: d = slot_rd2;
            default: d = slot_rd3;
         endcase
      end
      return {err, d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Driver: present one request while the bridge is idle, hold it over one edge.
   task automatic drive_req(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic push);
      tests++;
      if (req_ready !== 1'b1) begin
         fails++;
         $display("FAIL accept_ready: req_ready=%b expected 1 (addr %h)", req_ready, addr);
      end
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      if (push) exp_q.push_back(model_resp(we, addr));
      tick();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      resp_ready = 1'b0;
      #12;
      tests++;
      if (req_ready !== 1'b1) begin
         fails++; $display("FAIL reset_req_ready: got %b expected 1", req_ready);
      end
      tests++;
      if ({resp_valid, resp_err, resp_rdata} !== 34'd0) begin
         fails++; $display("FAIL reset_resp: valid=%b err=%b rdata=%h expected all 0", resp_valid, resp_err, resp_rdata);
      end
      tests++;
      if ({periph_write_en, periph_read_en, periph_addr_word, periph_wdata} !== 45'd0) begin
         fails++; $display("FAIL reset_periph: we=%b re=%b aw=%0d wd=%h expected all 0",
                           periph_write_en, periph_read_en, periph_addr_word, periph_wdata);
      end
      tests++;
      if (dbg_state !== 2'd0) begin
         fails++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_write_hit();
      logic [32:0] exp;
      resp_ready = 1'b1;
      drive_req(1'b1, 32'h4000_0004, 32'h0000_00FF, 1'b1);
      // SETUP
      tests++;
      if ({periph_write_en, periph_read_en, resp_valid, req_ready} !== 10'd0 ||
          periph_addr_word !== 5'd1 || periph_wdata !== 32'hFF) begin
         fails++; $display("FAIL wr_setup: we=%b re=%b aw=%0d wd=%h rv=%b rr=%b expected 0/0/1/ff/0/0",
                           periph_write_en, periph_read_en, periph_addr_word, periph_wdata, resp_valid, req_ready);
      end
      tick(); // ACCESS
      tests++;
      if (periph_write_en !== 4'b0001 || periph_read_en !== 4'b0000 || resp_valid !== 1'b0) begin
         fails++; $display("FAIL wr_access: we=%b re=%b rv=%b expected 0001/0000/0", periph_write_en, periph_read_en, resp_valid);
      end
      tests++;
      if (periph_addr_word !== 5'd1 || periph_wdata !== 32'hFF) begin
         fails++; $display("FAIL wr_access_bus: aw=%0d wd=%h expected 1/ff", periph_addr_word, periph_wdata);
      end
      tick(); // RESP
      tests++;
      if (periph_write_en !== 4'b0000) begin
         fails++; $display("FAIL wr_strobe_width: we=%b expected 0000", periph_write_en);
      end
      tests++;
      if (exp_q.size() == 0) begin
         fails++; $display("FAIL wr_resp: response with no expected entry");
      end else begin
         exp = exp_q.pop_front();
         if ({resp_valid, resp_err, resp_rdata} !== {1'b1, exp}) begin
            fails++; $display("FAIL wr_resp: valid=%b err=%b rdata=%h expected 1/%b/%h", resp_valid, resp_err, resp_rdata, exp[32], exp[31:0]);
         end
      end
      tick();
      tests++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         fails++; $display("FAIL wr_idle: rr=%b rv=%b expected 1/0", req_ready, resp_valid);
      end
   endtask

   task automatic test_read_hit();
      logic [31:0] addrs [2] = '{32'h4000_0088, 32'h4000_01FC};
      logic [3:0]  strb  [2] = '{4'b0010, 4'b1000};
      logic [4:0]  words [2] = '{5'd2, 5'd31};
      logic [32:0] exp;
      resp_ready = 1'b1;
      slot_rd1   = 32'hDEAD_BEEF;
      slot_rd3   = $urandom;
      for (int i = 0; i < 2; i++) begin
         drive_req(1'b0, addrs[i], $urandom, 1'b1);
         tick(); // ACCESS
         tests++;
         if (periph_read_en !== strb[i] || periph_write_en !== 4'b0000 || periph_addr_word !== words[i]) begin
            fails++; $display("FAIL rd_access[%0d]: re=%b we=%b aw=%0d expected %b/0000/%0d",
                              i, periph_read_en, periph_write_en, periph_addr_word, strb[i], words[i]);
         end
         tick(); // RESP: read data must already be captured
         slot_rd1 = ~slot_rd1;
         slot_rd3 = ~slot_rd3;
         #1;
         tests++;
         if (exp_q.size() == 0) begin
            fails++; $display("FAIL rd_resp[%0d]: response with no expected entry", i);
         end else begin
            exp = exp_q.pop_front();
            if ({resp_valid, resp_err, resp_rdata, periph_read_en} !== {1'b1, exp, 4'b0000}) begin
               fails++; $display("FAIL rd_resp[%0d]: valid=%b err=%b rdata=%h re=%b expected 1/%b/%h/0000",
                                 i, resp_valid, resp_err, resp_rdata, periph_read_en, exp[32], exp[31:0]);
            end
         end
         tick();
      end
   endtask

   task automatic test_errors();
      logic [31:0] addrs [2] = '{32'h4000_0200, 32'h4000_0002};
      logic        wes   [2] = '{1'b0, 1'b1};
      logic [32:0] exp;
      resp_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive_req(wes[i], addrs[i], 32'hA5A5_0000 + i, 1'b1);
         tests++;
         if ({periph_write_en, periph_read_en, resp_valid} !== 9'd0) begin
            fails++; $display("FAIL err_setup[%0d]: we=%b re=%b rv=%b expected 0000/0000/0", i, periph_write_en, periph_read_en, resp_valid);
         end
         tick(); // RESP after two cycles
         tests++;
         if (exp_q.size() == 0) begin
            fails++; $display("FAIL err_resp[%0d]: response with no expected entry", i);
         end else begin
            exp = exp_q.pop_front();
            if ({resp_valid, resp_err, resp_rdata, periph_write_en, periph_read_en} !== {1'b1, exp, 8'd0}) begin
               fails++; $display("FAIL err_resp[%0d]: valid=%b err=%b rdata=%h we=%b re=%b expected 1/%b/%h/0000/0000",
                                 i, resp_valid, resp_err, resp_rdata, periph_write_en, periph_read_en, exp[32], exp[31:0]);
            end
         end
         tick();
         tests++;
         if (req_ready !== 1'b1 || {periph_write_en, periph_read_en} !== 8'd0) begin
            fails++; $display("FAIL err_idle[%0d]: rr=%b we=%b re=%b expected 1/0000/0000", i, req_ready, periph_write_en, periph_read_en);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [32:0] exp;
      logic [31:0] gpio1;
      gpio1      = gpio_regs[1];
      resp_ready = 1'b0;
      slot_rd1   = 32'hCAFE_F00D;
      drive_req(1'b0, 32'h4000_008C, 32'h0, 1'b1);
      tick();
      tick(); // RESP
      // A competing write waits on the request channel throughout.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h4000_0004;
      req_wdata = 32'h0000_0077;
      for (int k = 0; k < 10; k++) begin
         tick();
         tests++;
         if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE_F00D || resp_err !== 1'b0 || req_ready !== 1'b0 ||
             {periph_write_en, periph_read_en} !== 8'd0 || dbg_state !== 2'd3) begin
            fails++; $display("FAIL bp_hold[%0d]: rv=%b rdata=%h err=%b rr=%b we=%b re=%b st=%0d expected 1/cafef00d/0/0/0000/0000/3",
                              k, resp_valid, resp_rdata, resp_err, req_ready, periph_write_en, periph_read_en, dbg_state);
         end
      end
      tests++;
      if (exp_q.size() == 0) begin
         fails++; $display("FAIL bp_resp: response with no expected entry");
      end else begin
         exp = exp_q.pop_front();
         if ({resp_valid, resp_err, resp_rdata} !== {1'b1, exp}) begin
            fails++; $display("FAIL bp_resp: valid=%b err=%b rdata=%h expected 1/%b/%h", resp_valid, resp_err, resp_rdata, exp[32], exp[31:0]);
         end
      end
      resp_ready = 1'b1;
      req_valid  = 1'b0;
      tick();
      tests++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
         fails++; $display("FAIL bp_release: rv=%b rr=%b rdata=%h err=%b expected 0/1/0/0", resp_valid, req_ready, resp_rdata, resp_err);
      end
      tests++;
      if (gpio_regs[1] !== gpio1) begin
         fails++; $display("FAIL bp_no_write: gpio[1]=%h expected %h", gpio_regs[1], gpio1);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] wd;
      logic [32:0] exp;
      wd         = $urandom;
      resp_ready = 1'b1;
      drive_req(1'b1, 32'h4000_0004, wd, 1'b1);
      tick(); // write ACCESS
      tick(); // write RESP
      tests++;
      if (exp_q.size() == 0) begin
         fails++; $display("FAIL b2b_wr_resp: response with no expected entry");
      end else begin
         exp = exp_q.pop_front();
         if ({resp_valid, resp_err, resp_rdata} !== {1'b1, exp}) begin
            fails++; $display("FAIL b2b_wr_resp: valid=%b err=%b rdata=%h expected 1/%b/%h", resp_valid, resp_err, resp_rdata, exp[32], exp[31:0]);
         end
      end
      // Read is presented early and must be taken the cycle after RESP.
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h4000_0004;
      exp_q.push_back({1'b0, wd});
      tick();
      tests++;
      if (req_ready !== 1'b1) begin
         fails++; $display("FAIL b2b_ready: rr=%b expected 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
      tick(); // read ACCESS
      tick(); // read RESP
      tests++;
      if (exp_q.size() == 0) begin
         fails++; $display("FAIL b2b_rd_resp: response with no expected entry");
      end else begin
         exp = exp_q.pop_front();
         if ({resp_valid, resp_err, resp_rdata} !== {1'b1, exp}) begin
            fails++; $display("FAIL b2b_rd_resp: valid=%b err=%b rdata=%h expected 1/%b/%h", resp_valid, resp_err, resp_rdata, exp[32], exp[31:0]);
         end
      end
      tests++;
      if (last_rd_cyc - last_wr_cyc != 4) begin
         fails++; $display("FAIL b2b_spacing: strobe gap=%0d expected 4", last_rd_cyc - last_wr_cyc);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int wp;
      int rp;
      wp         = wr_pulses;
      rp         = rd_pulses;
      resp_ready = 1'b1;
      drive_req(1'b1, 32'h4000_0010, 32'h1234_5678, 1'b0);
      rst_n = 1'b0; // during SETUP
      #1;
      tests++;
      if (req_ready !== 1'b1 || {resp_valid, periph_write_en, periph_read_en, periph_addr_word, periph_wdata} !== 46'd0) begin
         fails++; $display("FAIL rstmid_async: rr=%b rv=%b we=%b aw=%0d wd=%h expected 1/0/0000/0/0",
                           req_ready, resp_valid, periph_write_en, periph_addr_word, periph_wdata);
      end
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         tests++;
         if (req_ready !== 1'b1 || {resp_valid, resp_err, resp_rdata} !== 34'd0 ||
             {periph_write_en, periph_read_en, periph_addr_word, periph_wdata} !== 45'd0) begin
            fails++; $display("FAIL rstmid_idle[%0d]: rr=%b rv=%b err=%b rdata=%h we=%b re=%b aw=%0d wd=%h expected 1 and all else 0",
                              k, req_ready, resp_valid, resp_err, resp_rdata, periph_write_en, periph_read_en, periph_addr_word, periph_wdata);
         end
      end
      tests++;
      if (wr_pulses != wp || rd_pulses != rp || gpio_regs[4] !== 32'h0) begin
         fails++; $display("FAIL rstmid_no_strobe: wr_pulses=%0d rd_pulses=%0d gpio[4]=%h expected %0d/%0d/0",
                           wr_pulses, rd_pulses, gpio_regs[4], wp, rp);
      end
   endtask

   // Test sequence and final report
   initial begin
      test_reset();
      test_write_hit();
      test_read_hit();
      test_errors();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      tests++;
      if (exp_q.size() != 0) begin
         fails++; $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/qar_periph_bridge.md
Name: qar_periph_bridge

Overview:
- Initiator side of the word-addressed peripheral register interface (write_en/read_en/addr_word/wdata/rdata) used by the QAR peripherals (GPIO, timers, UART).
- Accepts one CPU load/store request at a time over a valid/ready handshake and decodes it to one of NUM_SLAVES peripheral slots.
- Drives a single-cycle strobe to the selected slot and captures its combinational read data.
- Returns a response over a valid/ready handshake; flags decode and alignment errors without touching any peripheral.

Parameters:
- BASE_ADDR, 32'h4000_0000, byte base of the peripheral window; must be aligned to NUM_SLAVES*2^SLOT_BITS.
- NUM_SLAVES, 4, number of peripheral slots; power of two, 2..16.
- SLOT_BITS, 7, log2 of slot size in bytes (128 B = 32 words, matching addr_word[4:0]).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  bridge can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- resp_valid  out  1  response valid.
- resp_ready  in  1  CPU accepts the response.
- resp_rdata  out  32  read data; 0 for writes and errors.
- resp_err  out  1  decode or alignment error.
- periph_write_en  out  NUM_SLAVES  one-hot write strobe.
- periph_read_en  out  NUM_SLAVES  one-hot read strobe.
- periph_addr_word  out  5  word offset within the slot.
- periph_wdata  out  32  write data.
- periph_rdata  in  NUM_SLAVES*32  concatenated slave read data; slot i occupies bits [32i+31:32i].

Behaviour:
- Reset values: all outputs 0 except req_ready=1; FSM in IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid (handshake), register we, addr_word=req_addr[6:2], wdata, slot index and error flag; go to SETUP.
  - req_ready=0 in every other state.
- Decode (computed at accept):
  - Hit when req_addr[31:SLOT_BITS+log2(NUM_SLAVES)] equals the same bits of BASE_ADDR.
  - Slot = req_addr[SLOT_BITS+log2(NUM_SLAVES)-1:SLOT_BITS].
  - Error = miss OR req_addr[1:0]!=0.
- SETUP:
  - periph_addr_word and periph_wdata are stable; strobes are low.
  - No error: go to ACCESS.
  - Error: go to RESP with resp_err=1 and resp_rdata=0; no strobe is ever asserted.
- ACCESS: exactly one cycle.
  - Write: periph_write_en[slot]=1.
  - Read: periph_read_en[slot]=1, and periph_rdata[slot] is sampled into resp_rdata at the clock edge ending the cycle.
  - Go to RESP.
- Strobes are registered outputs, high only in ACCESS and never two bits at once.
- periph_addr_word and periph_wdata hold their values from SETUP through RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_ready.
  - On resp_ready, go to IDLE, clear resp_valid, zero resp_rdata and resp_err.
- Latency: accept edge to resp_valid is 3 cycles for a hit and 2 cycles for an error.
- Throughput: at best one transaction per 4 cycles (a new request can be accepted the cycle after RESP completes).
- Backpressure: resp_ready held low keeps the bridge in RESP indefinitely; no new request is accepted and no strobe is issued.
- Slot writes take effect at the ACCESS edge, so a write followed by a read of the same register returns the new value.
- Reset mid-transaction: returns to IDLE immediately and drops the in-flight request with no strobe and no response. If reset asserts during ACCESS, the strobe deasserts asynchronously.
- Addresses at byte offsets 0x7C..0x7F of a slot decode to addr_word 31 (a legal hit).

Decomposition:
- Shared package qar_bus_pkg: FSM state encoding (2-bit); SLOT_BITS default; QAR_PERIPH_BASE; slot index constants (GPIO=0, TIMER=1, UART=2, spare=3).
- One sub-module: qar_addr_decode, combinational address→{hit, slot, aligned, addr_word}. Parameterised by BASE_ADDR, NUM_SLAVES and SLOT_BITS; reusable by a future DMA initiator.

Test Plan:
- Write 0x4000_0004 with data 0x0000_00FF (resp_ready=1): cycle 2 after accept has periph_write_en=4'b0001, addr_word=1, wdata=0xFF for one cycle; resp_valid at cycle 3 with err=0, rdata=0.
- Read 0x4000_0088 with slot-1 rdata=0xDEAD_BEEF and other slots 0: periph_read_en=4'b0010, addr_word=2; resp_rdata=0xDEAD_BEEF, err=0.
- Read 0x4000_0200 (outside the window) and write 0x4000_0002 (misaligned): no strobe in any cycle; resp_valid 2 cycles after accept with err=1, rdata=0.
- resp_ready held low for 10 cycles after a read: resp_valid and resp_rdata stay stable, req_ready=0, a pending req_valid is not accepted; releasing resp_ready returns to IDLE with req_ready=1 the next cycle.
- Back-to-back write 0x4000_0004 then read of the same address against a GPIO model: the read returns the written value; the strobes of the two transactions are separated by 4 cycles.
- rst_n asserted during SETUP of a write: no periph_write_en pulse and no resp_valid; after release req_ready=1 and all outputs are 0.
